router_pkt_tx: RTL

Packet transmitter that drives the router's input port. It accepts a request (destination, length), collects the payload from a byte source into an internal buffer, and emits the packet back-to-back: header, payload, then the parity byte. It honours the router's `busy` back-pressure and sits between a traffic source or CPU-side adapter and the router's `data_in`/`pkt_valid` input.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_tx_buf.sv | 23 ++
 rtl/router_pkt_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, port count, transmitter states
// and the header/parity helpers used by the packet transmitter.
package router_pkg;

    localparam int LEN_W     = 6;
    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } tx_state_t;

    function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len_v,
                                               input logic [ADDR_W-1:0] dest_v);
        return {len_v, dest_v};
    endfunction

    function automatic logic [7:0] parity_update(input logic [7:0] acc_v,
                                                 input logic [7:0] byte_v);
        return acc_v ^ byte_v;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8 register array, one synchronous write port and one
// combinational read port. The data array is intentionally not reset.
module router_tx_buf (
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_r [64];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a whole payload, then sends
// header, payload and parity back-to-back under busy back-pressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest,
    input  logic [LEN_W-1:0]  len,
    input  logic              corrupt_parity,
    input  logic [7:0]        pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic [7:0]        data_out,
    output logic              pkt_valid,
    output logic              tx_done,
    output logic              req_err,
    output logic              idle
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t         state_r, state_nx_s;
    logic [ADDR_W-1:0] dest_r;
    logic [LEN_W-1:0]  len_r;
    logic              corrupt_r;
    logic [5:0]        wr_cnt_r;
    logic [5:0]        rd_ptr_r;
    logic [7:0]        parity_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [7:0]        data_out_r;
    logic              pkt_valid_r, pl_ready_r, tx_done_r, req_err_r, idle_r;
    logic              accept_s, reject_s, wr_en_s;
    logic [7:0]        rd_data_s;

    router_tx_buf u_buf (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_cnt_r),
        .wdata (pl_data),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Next-state and request/capture decode
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        wr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((dest >= ADDR_W'(NUM_PORTS)) || (len == {LEN_W{1'b0}})) begin
                        reject_s = 1'b1;
                    end else begin
                        accept_s   = 1'b1;
                        state_nx_s = ST_COLLECT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                wr_en_s = pl_valid & pl_ready_r;
                if (wr_en_s && (wr_cnt_r == (len_r - 6'd1))) begin
                    state_nx_s = ST_HEADER;
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    state_nx_s = ST_PAYLOAD;
                end else begin
                    state_nx_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                // rd_ptr_r == len_r means the last payload byte is on data_out
                if (!busy && (rd_ptr_r == len_r)) begin
                    state_nx_s = ST_PARITY;
                end else begin
                    state_nx_s = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    state_nx_s = ST_GAP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register, counters, parity accumulator and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            dest_r      <= {ADDR_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            corrupt_r   <= 1'b0;
            wr_cnt_r    <= 6'd0;
            rd_ptr_r    <= 6'd0;
            parity_r    <= 8'd0;
            gap_cnt_r   <= {GAP_W{1'b0}};
            data_out_r  <= 8'd0;
            pkt_valid_r <= 1'b0;
            pl_ready_r  <= 1'b0;
            tx_done_r   <= 1'b0;
            req_err_r   <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            pl_ready_r <= (state_nx_s == ST_COLLECT);
            idle_r     <= (state_nx_s == ST_IDLE);
            req_err_r  <= reject_s;
            tx_done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    data_out_r  <= 8'd0;
                    pkt_valid_r <= 1'b0;
                    if (accept_s) begin
                        dest_r    <= dest;
                        len_r     <= len;
                        corrupt_r <= corrupt_parity;
                        wr_cnt_r  <= 6'd0;
                        parity_r  <= pack_header(len, dest);
                    end
                end
                ST_COLLECT: begin
                    if (wr_en_s) begin
                        wr_cnt_r <= wr_cnt_r + 6'd1;
                        parity_r <= parity_update(parity_r, pl_data);
                    end
                    if (state_nx_s == ST_HEADER) begin
                        data_out_r  <= pack_header(len_r, dest_r);
                        pkt_valid_r <= 1'b1;
                        rd_ptr_r    <= 6'd0;
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        data_out_r <= rd_data_s;
                        rd_ptr_r   <= rd_ptr_r + 6'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (rd_ptr_r == len_r) begin
                            data_out_r  <= parity_r ^ {8{corrupt_r}};
                            pkt_valid_r <= 1'b0;
                        end else begin
                            data_out_r <= rd_data_s;
                            rd_ptr_r   <= rd_ptr_r + 6'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        data_out_r <= 8'd0;
                        tx_done_r  <= 1'b1;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                    end
                end
                ST_GAP: begin
                    gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    data_out_r  <= 8'd0;
                    pkt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_r;
    assign pkt_valid = pkt_valid_r;
    assign pl_ready  = pl_ready_r;
    assign tx_done   = tx_done_r;
    assign req_err   = req_err_r;
    assign idle      = idle_r;

endmodule
